xadc_drp_scheduler: RTL and testbench

Sequences and shares the XADC dynamic reconfiguration port (DRP) between two requesters. The first is an automatic round-robin channel scanner triggered by end-of-conversion. The second is a configuration port that issues arbitrary DRP reads and writes, for example sequencer or alarm register setup. The block sits between the XADC wizard instance and downstream consumers such as PWM or LED logic and filters. It emits tagged 12-bit samples and completes configuration transactions with a DRP timeout guard.

---
 rtl/xadc_pkg.sv | 20 ++
 rtl/xadc_drp_arb.sv | 40 ++++
 rtl/xadc_drp_scheduler.sv | 175 +++++++++++++++++
 tb/tb_xadc_drp_scheduler.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xadc_pkg.sv
// Shared constants and types for the XADC DRP scheduler: DRP field widths,
// the scanned-channel address table and the scheduler state encoding.
package xadc_pkg;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 16;
    localparam int SMP_W  = 12;

    // Scan order: channel index i reads DRP address CH_ADDR[i].
    localparam logic [ADDR_W-1:0] CH_ADDR [8] = '{
        7'h1E, 7'h17, 7'h1F, 7'h16, 7'h1C, 7'h1D, 7'h14, 7'h15
    };

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SCAN_WAIT = 2'd1,
        ST_CFG_WAIT  = 2'd2
    } state_e;

endpackage

// File: rtl/xadc_drp_arb.sv
// Two-way DRP grant between the channel scanner and the configuration port,
// with a priority bit that alternates only when both sides compete.
module xadc_drp_arb (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic scan_req,
    input  logic cfg_req,
    output logic gnt_scan,
    output logic gnt_cfg
);

    // prio_q = 0 favours the scanner, 1 favours the configuration port.
    logic prio_q, prio_d;

    always_comb begin
        gnt_scan = 1'b0;
        gnt_cfg  = 1'b0;
        prio_d   = prio_q;
        if (en) begin
            if (scan_req && cfg_req) begin
                gnt_scan = ~prio_q;
                gnt_cfg  = prio_q;
                prio_d   = ~prio_q;
            end else begin
                gnt_scan = scan_req;
                gnt_cfg  = cfg_req;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/xadc_drp_scheduler.sv
// Shares the XADC DRP between an eoc-driven round-robin channel scanner and a
// configuration port; one transaction in flight, guarded by a drdy timeout.
module xadc_drp_scheduler
    import xadc_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              eoc,
    output logic              drp_den,
    output logic              drp_dwe,
    output logic [ADDR_W-1:0] drp_daddr,
    output logic [DATA_W-1:0] drp_di,
    input  logic [DATA_W-1:0] drp_do,
    input  logic              drp_drdy,
    input  logic              cfg_req,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [DATA_W-1:0] cfg_wdata,
    output logic              cfg_done,
    output logic [DATA_W-1:0] cfg_rdata,
    output logic              smp_valid,
    output logic [2:0]        smp_ch,
    output logic [SMP_W-1:0]  smp_data,
    output logic              err_timeout,
    output logic              err_overrun
);

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [2:0]       LAST_CH  = 3'(NUM_CH - 1);

    state_e            state_q, state_d;
    logic [2:0]        ch_idx_q, ch_idx_d;
    logic              eoc_pend_q, eoc_pend_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              den_q, den_d, dwe_q, dwe_d;
    logic [ADDR_W-1:0] daddr_q, daddr_d;
    logic [DATA_W-1:0] di_q, di_d, rdata_q, rdata_d;
    logic              done_q, done_d, smp_valid_q, smp_valid_d;
    logic [2:0]        smp_ch_q, smp_ch_d;
    logic [SMP_W-1:0]  smp_data_q, smp_data_d;
    logic              err_to_q, err_to_d, err_ov_q, err_ov_d;
    logic              in_idle, scan_req, cfg_req_eff, gnt_scan, gnt_cfg;

    assign in_idle  = (state_q == ST_IDLE);
    assign scan_req = eoc_pend_q | eoc;
    // The requester still holds cfg_req during its completion cycle; that is not a new request.
    assign cfg_req_eff = cfg_req & ~done_q;

    xadc_drp_arb u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (in_idle),
        .scan_req (scan_req),
        .cfg_req  (cfg_req_eff),
        .gnt_scan (gnt_scan),
        .gnt_cfg  (gnt_cfg)
    );

    always_comb begin
        state_d     = state_q;
        ch_idx_d    = ch_idx_q;
        cnt_d       = cnt_q;
        den_d       = 1'b0;
        dwe_d       = 1'b0;
        daddr_d     = daddr_q;
        di_d        = di_q;
        done_d      = 1'b0;
        rdata_d     = rdata_q;
        smp_valid_d = 1'b0;
        smp_ch_d    = smp_ch_q;
        smp_data_d  = smp_data_q;
        err_to_d    = 1'b0;
        err_ov_d    = eoc & eoc_pend_q;
        // A fresh eoc next to an already-pending one survives the grant that retires the old one.
        eoc_pend_d  = (eoc_pend_q | eoc) & ~(gnt_scan & ~(eoc & eoc_pend_q));

        unique case (state_q)
            ST_IDLE: begin
                if (gnt_scan) begin
                    den_d   = 1'b1;
                    daddr_d = CH_ADDR[ch_idx_q];
                    cnt_d   = '0;
                    state_d = ST_SCAN_WAIT;
                end else if (gnt_cfg) begin
                    den_d   = 1'b1;
                    dwe_d   = cfg_we;
                    daddr_d = cfg_addr;
                    di_d    = cfg_wdata;
                    cnt_d   = '0;
                    state_d = ST_CFG_WAIT;
                end
            end
            ST_SCAN_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (drp_drdy) begin
                    smp_valid_d = 1'b1;
                    smp_ch_d    = ch_idx_q;
                    smp_data_d  = drp_do[DATA_W-1:DATA_W-SMP_W];
                    ch_idx_d    = (ch_idx_q == LAST_CH) ? 3'd0 : ch_idx_q + 3'd1;
                    state_d     = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    err_to_d = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            ST_CFG_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (drp_drdy) begin
                    done_d  = 1'b1;
                    rdata_d = cfg_we ? rdata_q : drp_do;
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    err_to_d = 1'b1;
                    done_d   = 1'b1;
                    rdata_d  = 16'hFFFF;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ch_idx_q    <= 3'd0;
            eoc_pend_q  <= 1'b0;
            cnt_q       <= '0;
            den_q       <= 1'b0;
            dwe_q       <= 1'b0;
            daddr_q     <= CH_ADDR[0];
            di_q        <= '0;
            done_q      <= 1'b0;
            rdata_q     <= '0;
            smp_valid_q <= 1'b0;
            smp_ch_q    <= 3'd0;
            smp_data_q  <= '0;
            err_to_q    <= 1'b0;
            err_ov_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_idx_q    <= ch_idx_d;
            eoc_pend_q  <= eoc_pend_d;
            cnt_q       <= cnt_d;
            den_q       <= den_d;
            dwe_q       <= dwe_d;
            daddr_q     <= daddr_d;
            di_q        <= di_d;
            done_q      <= done_d;
            rdata_q     <= rdata_d;
            smp_valid_q <= smp_valid_d;
            smp_ch_q    <= smp_ch_d;
            smp_data_q  <= smp_data_d;
            err_to_q    <= err_to_d;
            err_ov_q    <= err_ov_d;
        end
    end

    assign drp_den     = den_q;
    assign drp_dwe     = dwe_q;
    assign drp_daddr   = daddr_q;
    assign drp_di      = di_q;
    assign cfg_done    = done_q;
    assign cfg_rdata   = rdata_q;
    assign smp_valid   = smp_valid_q;
    assign smp_ch      = smp_ch_q;
    assign smp_data    = smp_data_q;
    assign err_timeout = err_to_q;
    assign err_overrun = err_ov_q;

endmodule

// File: tb/tb_xadc_drp_scheduler.sv
// Bench for xadc_drp_scheduler: directed scenarios plus random traffic, every
// cycle compared against a transaction-level reference of the scheduler.
module tb_xadc_drp_scheduler;

    localparam int NUM_CH  = 4;
    localparam int TIMEOUT = 64;

    logic        clk;
    logic        rst_n;
    logic        eoc;
    logic        drp_den, drp_dwe;
    logic [6:0]  drp_daddr;
    logic [15:0] drp_di, drp_do;
    logic        drp_drdy;
    logic        cfg_req, cfg_we;
    logic [6:0]  cfg_addr;
    logic [15:0] cfg_wdata, cfg_rdata;
    logic        cfg_done, smp_valid;
    logic [2:0]  smp_ch;
    logic [11:0] smp_data;
    logic        err_timeout, err_overrun;

    xadc_drp_scheduler #(.NUM_CH(NUM_CH), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .eoc         (eoc),
        .drp_den     (drp_den),
        .drp_dwe     (drp_dwe),
        .drp_daddr   (drp_daddr),
        .drp_di      (drp_di),
        .drp_do      (drp_do),
        .drp_drdy    (drp_drdy),
        .cfg_req     (cfg_req),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .cfg_done    (cfg_done),
        .cfg_rdata   (cfg_rdata),
        .smp_valid   (smp_valid),
        .smp_ch      (smp_ch),
        .smp_data    (smp_data),
        .err_timeout (err_timeout),
        .err_overrun (err_overrun)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    logic [6:0]  ch_tab [8] = '{7'h1E, 7'h17, 7'h1F, 7'h16, 7'h1C, 7'h1D, 7'h14, 7'h15};
    int          m_busy;      // 0 nothing outstanding, 1 scan read, 2 config access
    int          m_age;       // cycles spent waiting since the enable
    bit          m_pend;      // an end-of-conversion waits to be scanned
    bit          m_prio_cfg;  // config side wins the next tie
    int          m_ch;
    logic [6:0]  m_addr;
    logic [15:0] m_di, m_rdata;
    logic        e_den, e_dwe, e_smp_valid, e_cfg_done, e_err_to, e_err_ov;
    logic [2:0]  e_smp_ch;
    logic [11:0] e_smp_data;

    task automatic model_reset();
        m_busy = 0; m_age = 0; m_pend = 0; m_prio_cfg = 0; m_ch = 0;
        m_addr = 7'h1E; m_di = 16'h0; m_rdata = 16'h0;
        e_den = 0; e_dwe = 0; e_smp_valid = 0; e_cfg_done = 0; e_err_to = 0; e_err_ov = 0;
        e_smp_ch = 0; e_smp_data = 0;
    endtask

    // Consumes this cycle's inputs, predicts next cycle's outputs.
    task automatic model_step();
        bit done_now, want_s, want_c, take_s, take_c;
        int p;
        done_now = e_cfg_done;
        e_den = 0; e_dwe = 0; e_smp_valid = 0; e_cfg_done = 0; e_err_to = 0;
        e_err_ov = eoc && m_pend;
        take_s = 0; take_c = 0;
        if (m_busy == 0) begin
            want_s = m_pend || eoc;
            want_c = cfg_req && !done_now;
            if (want_s && want_c) begin
                take_s = !m_prio_cfg;
                take_c = m_prio_cfg;
                m_prio_cfg = !m_prio_cfg;
            end else begin
                take_s = want_s;
                take_c = want_c;
            end
            if (take_s) begin
                e_den = 1; m_addr = ch_tab[m_ch]; m_busy = 1; m_age = 0;
            end
            if (take_c) begin
                e_den = 1; e_dwe = cfg_we; m_addr = cfg_addr; m_di = cfg_wdata; m_busy = 2; m_age = 0;
            end
        end else if (drp_drdy) begin
            if (m_busy == 1) begin
                e_smp_valid = 1; e_smp_ch = 3'(m_ch); e_smp_data = drp_do[15:4];
                m_ch = (m_ch + 1) % NUM_CH;
            end else begin
                e_cfg_done = 1;
                if (!cfg_we) m_rdata = drp_do;
            end
            m_busy = 0;
        end else if (m_age == TIMEOUT - 1) begin
            e_err_to = 1;
            if (m_busy == 2) begin
                e_cfg_done = 1; m_rdata = 16'hFFFF;
            end
            m_busy = 0;
        end else begin
            m_age++;
        end
        p = int'(m_pend) + int'(eoc) - int'(take_s);
        m_pend = (p > 0);
    endtask

    // ---------------- DRP slave / requester state ----------------
    logic [15:0] do_q[$];
    logic [11:0] exp_q[$];
    int   drdy_cnt = 0;
    int   slv_lat  = 3;
    bit   slv_rand = 0;
    bit   stray_en = 0;
    bit   cfg_release = 0;
    int   n_den = 0, n_smp = 0, n_ovr = 0, n_to = 0;
    int   den_cyc = 0, to_cyc = 0;
    logic [6:0] last_den_addr;
    logic [2:0] last_smp_ch;

    task automatic compare_outputs();
        check("den", drp_den, e_den);
        check("dwe", drp_dwe, e_dwe);
        if (m_busy != 0) check("daddr", drp_daddr, m_addr);
        if (m_busy == 2) check("di", drp_di, m_di);
        check("smp_valid", smp_valid, e_smp_valid);
        if (e_smp_valid) begin
            check("smp_ch", smp_ch, e_smp_ch);
            check("smp_data", smp_data, e_smp_data);
        end
        check("cfg_done", cfg_done, e_cfg_done);
        check("cfg_rdata", cfg_rdata, m_rdata);
        check("err_timeout", err_timeout, e_err_to);
        check("err_overrun", err_overrun, e_err_ov);
    endtask

    // One clock: sample just after the edge, then drive this cycle's inputs.
    task automatic tick(input logic e, input logic new_cfg, input logic we,
                        input logic [6:0] a, input logic [15:0] d);
        bit rel_now;
        int lat;
        @(posedge clk);
        #1;
        cyc++;
        compare_outputs();
        if (drp_den) begin n_den++; last_den_addr = drp_daddr; den_cyc = cyc; end
        if (smp_valid) begin
            n_smp++;
            last_smp_ch = smp_ch;
            if (exp_q.size() > 0) check("smp_scoreboard", smp_data, exp_q.pop_front());
        end
        if (err_overrun) n_ovr++;
        if (err_timeout) begin n_to++; to_cyc = cyc; end

        drp_drdy = 1'b0;
        if (drdy_cnt > 0) begin
            drdy_cnt--;
            if (drdy_cnt == 0) begin
                drp_drdy = 1'b1;
                if (do_q.size() > 0) drp_do = do_q.pop_front();
                else drp_do = 16'($urandom);
            end
        end else if (stray_en && !drp_den && $urandom_range(0, 49) == 0) begin
            drp_drdy = 1'b1;
            drp_do = 16'($urandom);
        end
        if (drp_den) begin
            if (slv_rand) lat = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 8));
            else lat = slv_lat;
            drdy_cnt = lat;
        end

        rel_now = cfg_release;
        if (cfg_release) begin cfg_req = 1'b0; cfg_release = 0; end
        if (cfg_done && cfg_req) cfg_release = 1;
        if (new_cfg && !cfg_req && !rel_now) begin
            cfg_req = 1'b1; cfg_we = we; cfg_addr = a; cfg_wdata = d;
        end
        eoc = e;
        model_step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 7'h0, 16'h0);
    endtask

    task automatic wait_cfg(input int limit);
        int k;
        logic expired;
        k = 0;
        while ((cfg_req || cfg_release) && k < limit) begin
            idle(1);
            k++;
        end
        expired = cfg_req || cfg_release;
        check("cfg_wait_bound", expired, 1'b0);
    endtask

    task automatic check_reset_outputs();
        check("rst_den", drp_den, 0);
        check("rst_dwe", drp_dwe, 0);
        check("rst_daddr", drp_daddr, 7'h1E);
        check("rst_di", drp_di, 0);
        check("rst_cfg_done", cfg_done, 0);
        check("rst_cfg_rdata", cfg_rdata, 0);
        check("rst_smp_valid", smp_valid, 0);
        check("rst_smp_ch", smp_ch, 0);
        check("rst_smp_data", smp_data, 0);
        check("rst_err_timeout", err_timeout, 0);
        check("rst_err_overrun", err_overrun, 0);
    endtask

    task automatic apply_reset(input int n);
        rst_n = 1'b0;
        eoc = 1'b0; cfg_req = 1'b0; cfg_release = 0; drp_drdy = 1'b0; drdy_cnt = 0;
        #1;
        check_reset_outputs();
        repeat (n) @(posedge clk);
        #1;
        check_reset_outputs();
        model_reset();
        rst_n = 1'b1;
        model_step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got no end, expected end");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] a0;
        int ov0, d0, s0, t0;
        rst_n = 1'b1; eoc = 1'b0; drp_do = 16'h0; drp_drdy = 1'b0;
        cfg_req = 1'b0; cfg_we = 1'b0; cfg_addr = 7'h0; cfg_wdata = 16'h0;
        last_den_addr = 7'h0; last_smp_ch = 3'd0;
        model_reset();
        #2;
        apply_reset(3);

        // Basic scan of four channels.
        slv_lat = 3;
        do_q = '{16'hABC0, 16'h1230, 16'h4560, 16'h7890};
        exp_q = '{12'hABC, 12'h123, 12'h456, 12'h789};
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b0, 1'b0, 7'h0, 16'h0);
            idle(19);
        end
        check("p1_scoreboard_empty", exp_q.size(), 0);

        // Scan and config write colliding, twice.
        for (int k = 0; k < 2; k++) begin
            tick(1'b1, 1'b1, 1'b1, 7'h41, 16'h2000);
            wait_cfg(200);
            idle(15);
        end

        // Config read.
        s0 = n_smp;
        do_q.push_back(16'h5A5A);
        tick(1'b0, 1'b1, 1'b0, 7'h40, 16'h0);
        wait_cfg(200);
        check("p3_rdata", cfg_rdata, 16'h5A5A);
        check("p3_no_sample", n_smp - s0, 0);

        // Scan without any drdy: abort and retry the same channel.
        slv_lat = 0;
        t0 = n_to;
        tick(1'b1, 1'b0, 1'b0, 7'h0, 16'h0);
        idle(TIMEOUT + 5);
        a0 = last_den_addr;
        check("p4_timeout_count", n_to - t0, 1);
        check("p4_timeout_latency", to_cyc - den_cyc, TIMEOUT);
        slv_lat = 3;
        tick(1'b1, 1'b0, 1'b0, 7'h0, 16'h0);
        idle(10);
        check("p4_same_addr", last_den_addr, a0);

        // Two extra eoc pulses during a scan.
        slv_lat = 10;
        ov0 = n_ovr; d0 = n_den;
        tick(1'b1, 1'b0, 1'b0, 7'h0, 16'h0);
        idle(2);
        tick(1'b1, 1'b0, 1'b0, 7'h0, 16'h0);
        idle(1);
        tick(1'b1, 1'b0, 1'b0, 7'h0, 16'h0);
        idle(30);
        check("p5_overrun_pulses", n_ovr - ov0, 1);
        check("p5_scan_count", n_den - d0, 2);

        // Reset in the middle of a scan, with the answer arriving afterwards.
        slv_lat = 5;
        tick(1'b1, 1'b0, 1'b0, 7'h0, 16'h0);
        idle(3);
        apply_reset(2);
        drdy_cnt = 2;
        s0 = n_smp;
        idle(6);
        check("p6_late_drdy_ignored", n_smp - s0, 0);
        last_den_addr = 7'h0;
        last_smp_ch = 3'd7;
        tick(1'b1, 1'b0, 1'b0, 7'h0, 16'h0);
        idle(10);
        check("p6_first_addr", last_den_addr, 7'h1E);
        check("p6_first_ch", last_smp_ch, 3'd0);

        // Random traffic.
        slv_rand = 1; stray_en = 1;
        for (int i = 0; i < 3000; i++) begin
            tick(1'($urandom_range(0, 11) == 0), 1'($urandom_range(0, 19) == 0),
                 1'($urandom), 7'($urandom), 16'($urandom));
        end
        slv_rand = 0; stray_en = 0; slv_lat = 3;
        idle(TIMEOUT + 20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
